// File: rtl/trim_pwm_deadband.sv
// trim_pwm_deadband: turns one PWM waveform into a complementary, non-overlapping
// gate-drive pair with programmable dead time, short-pulse swallow flag and kill.
module trim_pwm_deadband #(
    parameter int DeadTimeBits = 8,
    parameter int KillMode     = 0
) (
    input  logic                    i_clock,
    input  logic                    i_reset,
    input  logic                    i_en,
    input  logic                    i_pwm_in,
    input  logic [DeadTimeBits-1:0] i_dt,
    input  logic                    i_kill,
    input  logic                    i_kill_clr,
    output logic                    o_ph1,
    output logic                    o_ph2,
    output logic                    o_swallow
);
    typedef enum logic [2:0] {
        ST_LOW  = 3'd0,
        ST_DT_R = 3'd1,
        ST_HIGH = 3'd2,
        ST_DT_F = 3'd3,
        ST_KILL = 3'd4
    } state_t;

    localparam logic [DeadTimeBits-1:0] CNT_ONE = DeadTimeBits'(1);

    logic                    r_pwm_p0;
    logic                    r_kill_p0;
    state_t                  r_state_p1;
    state_t                  w_state_nxt;
    logic [DeadTimeBits-1:0] r_cnt_p1;
    logic [DeadTimeBits-1:0] w_cnt_nxt;
    logic                    r_ph1_p1;
    logic                    r_ph2_p1;
    logic                    r_swallow_p1;
    logic                    w_swallow_nxt;
    logic                    w_dt_zero;
    logic                    w_cnt_last;
    logic                    w_kill_exit;

    // Stage 0: input registers keep sampling even while en is low
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_pwm_p0  <= 1'b0;
            r_kill_p0 <= 1'b0;
        end else begin
            r_pwm_p0  <= i_pwm_in;
            r_kill_p0 <= i_kill;
        end
    end

    assign w_dt_zero   = (i_dt == '0);
    // Using <= 1 keeps a zero load from wrapping the counter
    assign w_cnt_last  = (r_cnt_p1 <= CNT_ONE);
    assign w_kill_exit = (KillMode == 0) || i_kill_clr;

    always_comb begin
        w_state_nxt   = r_state_p1;
        w_cnt_nxt     = r_cnt_p1;
        w_swallow_nxt = 1'b0;
        if (r_kill_p0) begin
            w_state_nxt = ST_KILL;
        end else if (i_en) begin
            case (r_state_p1)
                ST_LOW: begin
                    if (r_pwm_p0) begin
                        if (w_dt_zero) begin
                            w_state_nxt = ST_HIGH;
                        end else begin
                            w_state_nxt = ST_DT_R;
                            w_cnt_nxt   = i_dt;
                        end
                    end
                end
                ST_DT_R: begin
                    if (!r_pwm_p0) begin
                        w_state_nxt   = ST_LOW;
                        w_swallow_nxt = 1'b1;
                    end else if (w_cnt_last) begin
                        w_state_nxt = ST_HIGH;
                    end else begin
                        w_cnt_nxt = r_cnt_p1 - CNT_ONE;
                    end
                end
                ST_HIGH: begin
                    if (!r_pwm_p0) begin
                        if (w_dt_zero) begin
                            w_state_nxt = ST_LOW;
                        end else begin
                            w_state_nxt = ST_DT_F;
                            w_cnt_nxt   = i_dt;
                        end
                    end
                end
                ST_DT_F: begin
                    // A new rising edge during falling dead time re-arms without swallow
                    if (r_pwm_p0) begin
                        w_state_nxt = ST_DT_R;
                        w_cnt_nxt   = i_dt;
                    end else if (w_cnt_last) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_cnt_nxt = r_cnt_p1 - CNT_ONE;
                    end
                end
                ST_KILL: begin
                    if (w_kill_exit) begin
                        w_state_nxt = ST_DT_F;
                        w_cnt_nxt   = i_dt;
                    end
                end
                default: begin
                    w_state_nxt = ST_DT_F;
                    w_cnt_nxt   = i_dt;
                end
            endcase
        end
    end

    // Stage 1: FSM state, dead-time counter and registered outputs
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            r_state_p1   <= ST_DT_F;
            r_cnt_p1     <= i_dt;
            r_ph1_p1     <= 1'b0;
            r_ph2_p1     <= 1'b0;
            r_swallow_p1 <= 1'b0;
        end else begin
            r_state_p1   <= w_state_nxt;
            r_cnt_p1     <= w_cnt_nxt;
            r_ph1_p1     <= (w_state_nxt == ST_HIGH);
            r_ph2_p1     <= (w_state_nxt == ST_LOW);
            r_swallow_p1 <= w_swallow_nxt;
        end
    end

    assign o_ph1     = r_ph1_p1;
    assign o_ph2     = r_ph2_p1;
    assign o_swallow = r_swallow_p1;

endmodule
